alu_share_arbiter: RTL and testbench

Two-requester arbiter and sequencer that time-shares the single-cycle 32-bit ALU between two independent clients, e.g. the main datapath and an address/immediate helper unit. It grants one request at a time using round-robin priority and registers the operation and operands toward the ALU. It then captures the ALU result and Zero flag and returns them to the granted client over a valid/ready response channel. One transaction is outstanding at a time.

---
 rtl/alu_share_arbiter.sv | 108 ++++++++++
 tb/tb_alu_share_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one single-cycle ALU between two requesters,
// registering operands toward the ALU and returning the captured result over valid/ready.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             r0_valid_i,
  output logic             r0_ready_o,
  input  logic [OP_W-1:0]  r0_op_i,
  input  logic [WIDTH-1:0] r0_a_i,
  input  logic [WIDTH-1:0] r0_b_i,
  output logic             r0_rsp_valid_o,
  input  logic             r0_rsp_ready_i,
  output logic [WIDTH-1:0] r0_result_o,
  output logic             r0_zero_o,

  input  logic             r1_valid_i,
  output logic             r1_ready_o,
  input  logic [OP_W-1:0]  r1_op_i,
  input  logic [WIDTH-1:0] r1_a_i,
  input  logic [WIDTH-1:0] r1_b_i,
  output logic             r1_rsp_valid_o,
  input  logic             r1_rsp_ready_i,
  output logic [WIDTH-1:0] r1_result_o,
  output logic             r1_zero_o,

  output logic [OP_W-1:0]  ALU_Operation_o,
  output logic [WIDTH-1:0] A_o,
  output logic [WIDTH-1:0] B_o,
  input  logic [WIDTH-1:0] ALU_Result_i,
  input  logic             Zero_i
);

  // state | meaning
  // IDLE  | accepting requests, ready driven combinationally
  // EXEC  | ALU evaluating the registered operands
  // RESP  | response held for the owner until rsp_ready
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             accept;
  logic             owner_rsp_ready;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 1'b0;
    if (r0_valid_i && r1_valid_i) grant = ~last_grant;
    else if (r1_valid_i)          grant = 1'b1;
  end

  assign r0_ready_o      = (state == IDLE) && r0_valid_i && !grant;
  assign r1_ready_o      = (state == IDLE) && r1_valid_i &&  grant;
  assign accept          = r0_ready_o || r1_ready_o;
  assign owner_rsp_ready = owner ? r1_rsp_ready_i : r0_rsp_ready_i;

  assign r0_rsp_valid_o = (state == RESP) && !owner;
  assign r1_rsp_valid_o = (state == RESP) &&  owner;
  assign r0_result_o    = result_q;
  assign r1_result_o    = result_q;
  assign r0_zero_o      = zero_q;
  assign r1_zero_o      = zero_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      owner           <= 1'b0;
      ALU_Operation_o <= '0;
      A_o             <= '0;
      B_o             <= '0;
      result_q        <= '0;
      zero_q          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ALU_Operation_o <= grant ? r1_op_i : r0_op_i;
            A_o             <= grant ? r1_a_i  : r0_a_i;
            B_o             <= grant ? r1_b_i  : r0_b_i;
            owner           <= grant;
            last_grant      <= grant;
            state           <= EXEC;
          end
        end
        EXEC: begin
          result_q <= ALU_Result_i;
          zero_q   <= Zero_i;
          state    <= RESP;
        end
        RESP: begin
          if (owner_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: behavioural ALU plus a transaction-level model of
// grant order and response timing, directed scenarios then randomized traffic.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic        vld[2];
  logic [3:0]  op[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  logic        rrdy[2];

  logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid, r0_zero, r1_zero;
  logic [31:0] r0_result, r1_result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero;

  int tests = 0;
  int fails = 0;

  alu_share_arbiter #(.WIDTH(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .r0_valid_i(vld[0]), .r0_ready_o(r0_ready), .r0_op_i(op[0]), .r0_a_i(a[0]), .r0_b_i(b[0]),
    .r0_rsp_valid_o(r0_rsp_valid), .r0_rsp_ready_i(rrdy[0]), .r0_result_o(r0_result), .r0_zero_o(r0_zero),
    .r1_valid_i(vld[1]), .r1_ready_o(r1_ready), .r1_op_i(op[1]), .r1_a_i(a[1]), .r1_b_i(b[1]),
    .r1_rsp_valid_o(r1_rsp_valid), .r1_rsp_ready_i(rrdy[1]), .r1_result_o(r1_result), .r1_zero_o(r1_zero),
    .ALU_Operation_o(alu_op), .A_o(alu_a), .B_o(alu_b),
    .ALU_Result_i(alu_res), .Zero_i(alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      4'b0000: return x + y;
      4'b0001: return x - y;
      4'b0010: return x & y;
      4'b0011: return x | y;
      4'b0100: return x ^ y;
      4'b1000: return {y[19:0], 12'h000};
      4'b1001: return x | y;
      default: return 32'h0;
    endcase
  endfunction

  assign alu_res  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_res == 32'h0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: busy between accept and response handshake.
  bit          busy, owner, last;
  int          cyc, acc_cyc;
  logic [3:0]  h_op;
  logic [31:0] h_a, h_b;
  bit          acc[2];
  bit          seen_rv[2], seen_rdy[2];
  logic [31:0] seen_res[2];
  logic        seen_z[2];
  logic [3:0]  ops[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b1000, 4'b1001, 4'b1111};

  task automatic model_reset();
    busy = 0; owner = 0; last = 1;
    h_op = '0; h_a = '0; h_b = '0;
    acc[0] = 0; acc[1] = 0;
  endtask

  task automatic step();
    bit exp_rdy[2], exp_rv[2];
    logic [31:0] exp_res;
    @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      exp_rdy[n] = !busy && vld[n] && (!vld[1-n] || last != n[0]);
      exp_rv[n]  = busy && owner == n[0] && (cyc >= acc_cyc + 2);
    end
    seen_rdy[0] = r0_ready;     seen_rdy[1] = r1_ready;
    seen_rv[0]  = r0_rsp_valid; seen_rv[1]  = r1_rsp_valid;
    seen_res[0] = r0_result;    seen_res[1] = r1_result;
    seen_z[0]   = r0_zero;      seen_z[1]   = r1_zero;
    check("ready0", r0_ready, exp_rdy[0]);
    check("ready1", r1_ready, exp_rdy[1]);
    check("rsp_valid0", r0_rsp_valid, exp_rv[0]);
    check("rsp_valid1", r1_rsp_valid, exp_rv[1]);
    check("alu_op", alu_op, h_op);
    check("alu_a", alu_a, h_a);
    check("alu_b", alu_b, h_b);
    exp_res = alu_fn(h_op, h_a, h_b);
    for (int n = 0; n < 2; n++) if (exp_rv[n]) begin
      check("result", seen_res[n], exp_res);
      check("zero", seen_z[n], exp_res == 32'h0);
    end
    @(posedge clk);
    acc[0] = 0; acc[1] = 0;
    if (busy && exp_rv[owner] && rrdy[owner]) busy = 0;
    else if (!busy) begin
      for (int n = 0; n < 2; n++) if (exp_rdy[n]) begin
        acc[n] = 1; busy = 1; owner = n[0]; last = n[0]; acc_cyc = cyc;
        h_op = op[n]; h_a = a[n]; h_b = b[n];
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int n = 0; n < 2; n++) begin vld[n] = 0; op[n] = '0; a[n] = '0; b[n] = '0; rrdy[n] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic new_req(input int n);
    int r;
    vld[n] = 1;
    op[n]  = ops[$urandom_range(0, 7)];
    a[n]   = $urandom;
    r      = $urandom_range(0, 3);
    b[n]   = (r == 0) ? a[n] : (r == 1) ? -a[n] : $urandom;
  endtask

  task automatic run_one(input int n, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_res, input logic exp_z, input string tag);
    vld[n] = 1; op[n] = o; a[n] = x; b[n] = y; rrdy[n] = 1;
    step();
    check({tag, "_ready"}, seen_rdy[n], 1);
    vld[n] = 0;
    step();
    check({tag, "_early_rv"}, seen_rv[n], 0);
    step();
    check({tag, "_rv"}, seen_rv[n], 1);
    check({tag, "_other_rv"}, seen_rv[1-n], 0);
    check({tag, "_res"}, seen_res[n], exp_res);
    check({tag, "_zero"}, seen_z[n], exp_z);
  endtask

  initial begin
    int gq[$];
    logic [31:0] held;
    reset = 1'b0;
    cyc = 0; acc_cyc = 0;
    do_reset();

    // Reset values
    #3;
    check("rst_result", r0_result, 0);
    check("rst_zero", r1_zero, 0);
    step();

    run_one(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, "add");
    run_one(1, 4'b1000, 32'd0, 32'h00012345, 32'h12345000, 1'b0, "lui");
    run_one(1, 4'b1001, 32'hF0, 32'h0F, 32'hFF, 1'b0, "ori");
    run_one(0, 4'b0001, 32'd9, 32'd9, 32'd0, 1'b1, "sub_zero");
    run_one(0, 4'b0000, -32'd3, 32'd3, 32'd0, 1'b1, "add_zero");
    run_one(1, 4'b1111, 32'd4, 32'd4, 32'd0, 1'b1, "unsupported");

    // Alternating grants from reset with both requesters always valid
    do_reset();
    new_req(0); new_req(1); rrdy[0] = 1; rrdy[1] = 1;
    repeat (13) begin
      step();
      for (int n = 0; n < 2; n++) if (acc[n]) begin gq.push_back(n); new_req(n); end
    end
    check("grant_count", gq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) check("grant_order", gq[i], i % 2);

    // Owner stalls the response; the waiting requester wins right after the handshake
    do_reset();
    vld[0] = 1; op[0] = 4'b0000; a[0] = 32'd100; b[0] = 32'd23; rrdy[0] = 0;
    step();
    vld[0] = 0;
    step();
    new_req(1); rrdy[1] = 1;
    step();
    held = seen_res[0];
    check("stall_res", held, 32'd123);
    repeat (5) begin
      step();
      check("stall_rv", seen_rv[0], 1);
      check("stall_hold", seen_res[0], held);
      check("stall_no_ready", seen_rdy[1], 0);
    end
    rrdy[0] = 1;
    step();
    check("stall_handshake_no_acc", acc[1], 0);
    step();
    check("stall_next_acc", acc[1], 1);
    vld[1] = 0;
    step(); step();

    // Reset pulsed during EXEC
    do_reset();
    vld[0] = 1; op[0] = 4'b0000; a[0] = 32'd1; b[0] = 32'd2; rrdy[0] = 1;
    step();
    vld[0] = 0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("mid_rst_rv0", r0_rsp_valid, 0);
    check("mid_rst_rv1", r1_rsp_valid, 0);
    check("mid_rst_op", alu_op, 0);
    check("mid_rst_a", alu_a, 0);
    check("mid_rst_b", alu_b, 0);
    check("mid_rst_res", r0_result, 0);
    step(); step();
    reset = 1'b1;
    step();
    check("post_rst_rv", seen_rv[0], 0);
    new_req(0); new_req(1);
    step();
    check("post_rst_tie_r0", seen_rdy[0], 1);
    check("post_rst_tie_r1", seen_rdy[1], 0);
    vld[0] = 0;
    step(); step();

    // Randomized traffic
    do_reset();
    repeat (2000) begin
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          if ($urandom_range(0, 1) == 1) new_req(n); else vld[n] = 0;
        end else if (vld[n]) begin
          if ($urandom_range(0, 7) == 0) vld[n] = 0;
        end else if ($urandom_range(0, 1) == 1) begin
          new_req(n);
        end
        rrdy[n] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
